// File: rtl/round_combat_controller_if.sv
// Hit-request handshake bundle between the two hit-detection units and the
// round controller: per-character request, damage value and acceptance pulse.
interface round_combat_controller_if #(
   parameter int DMG_W = 8
);
   logic             hit1_req;
   logic [DMG_W-1:0] hit1_dmg;
   logic             hit1_ack;
   logic             hit2_req;
   logic [DMG_W-1:0] hit2_dmg;
   logic             hit2_ack;

   modport master (
      output hit1_req, hit1_dmg, hit2_req, hit2_dmg,
      input  hit1_ack, hit2_ack
   );

   modport slave (
      input  hit1_req, hit1_dmg, hit2_req, hit2_dmg,
      output hit1_ack, hit2_ack
   );
endinterface

// File: rtl/round_combat_controller.sv
// One fighting round: HP registers, round timer, KO/time-up detection and
// round-robin hit arbitration. Optional combo damage scaling: COMBO_SCALE_EN.
module round_combat_controller #(
   parameter int HP_MAX         = 100,
   parameter int HP_W           = 8,
   parameter int DMG_W          = 8,
   parameter int ROUND_SEC      = 60,
   parameter int FRAMES_PER_SEC = 60,
   parameter int COMBO_WINDOW   = 30
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     round_start,
   input  logic                     frame_tick,
   round_combat_controller_if.slave hits,
   output logic [HP_W-1:0]          hp1,
   output logic [HP_W-1:0]          hp2,
   output logic [6:0]               round_time,
   output logic                     round_active,
   output logic                     game_over,
   output logic [1:0]               winner
);

   localparam int W    = (HP_W > DMG_W) ? HP_W : DMG_W;
   localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);

   typedef enum logic [1:0] {IDLE, FIGHT, OVER} state_t;

   state_t            state, state_n;
   logic [HP_W-1:0]   hp1_n, hp2_n;
   logic [6:0]        time_n;
   logic [FC_W-1:0]   fcnt, fcnt_n;
   logic [1:0]        winner_n;
   logic              prio, prio_n;      // 0: hit1 wins next contention
   logic              ack1, ack2, ack1_n, ack2_n;
   logic              elig1, elig2, grant1, grant2, ko, time_up;
   logic [DMG_W-1:0]  dmg1, dmg2;

`ifdef COMBO_SCALE_EN
   localparam int CF_W = $clog2(COMBO_WINDOW + 2);
   logic [1:0]        last_atk, last_atk_n;
   logic [1:0]        combo, combo_n, combo1, combo2;
   logic [CF_W-1:0]   since, since_n;
`endif

   function automatic logic [HP_W-1:0] apply_hit(input logic [HP_W-1:0] hp,
                                                 input logic [DMG_W-1:0] dmg);
      logic [W-1:0] h, d;
      h = W'(hp);
      d = W'(dmg);
      return (d >= h) ? '0 : HP_W'(h - d);
   endfunction

   assign hits.hit1_ack = ack1;
   assign hits.hit2_ack = ack2;
   assign round_active  = (state == FIGHT);
   assign game_over     = (state == OVER);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         hp1        <= HP_W'(HP_MAX);
         hp2        <= HP_W'(HP_MAX);
         round_time <= 7'(ROUND_SEC);
         fcnt       <= '0;
         winner     <= 2'b00;
         prio       <= 1'b0;
         ack1       <= 1'b0;
         ack2       <= 1'b0;
`ifdef COMBO_SCALE_EN
         last_atk   <= 2'd0;
         combo      <= 2'd0;
         since      <= '0;
`endif
      end else begin
         state      <= state_n;
         hp1        <= hp1_n;
         hp2        <= hp2_n;
         round_time <= time_n;
         fcnt       <= fcnt_n;
         winner     <= winner_n;
         prio       <= prio_n;
         ack1       <= ack1_n;
         ack2       <= ack2_n;
`ifdef COMBO_SCALE_EN
         last_atk   <= last_atk_n;
         combo      <= combo_n;
         since      <= since_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      hp1_n    = hp1;
      hp2_n    = hp2;
      time_n   = round_time;
      fcnt_n   = fcnt;
      winner_n = winner;
      prio_n   = prio;
      ack1_n   = 1'b0;
      ack2_n   = 1'b0;
      ko       = 1'b0;
      time_up  = 1'b0;
      grant1   = 1'b0;
      grant2   = 1'b0;
      dmg1     = hits.hit1_dmg;
      dmg2     = hits.hit2_dmg;
      // A request whose ack is currently visible is already served.
      elig1    = hits.hit1_req & ~ack1;
      elig2    = hits.hit2_req & ~ack2;
`ifdef COMBO_SCALE_EN
      last_atk_n = last_atk;
      combo_n    = combo;
      since_n    = since;
      combo1 = (last_atk == 2'd1 && since <= CF_W'(COMBO_WINDOW))
               ? ((combo == 2'd3) ? 2'd3 : combo + 2'd1) : 2'd1;
      combo2 = (last_atk == 2'd2 && since <= CF_W'(COMBO_WINDOW))
               ? ((combo == 2'd3) ? 2'd3 : combo + 2'd1) : 2'd1;
      if (combo1 == 2'd3) dmg1 = hits.hit1_dmg >> 1;
      if (combo2 == 2'd3) dmg2 = hits.hit2_dmg >> 1;
`endif

      if (round_start) begin
         hp1_n    = HP_W'(HP_MAX);
         hp2_n    = HP_W'(HP_MAX);
         time_n   = 7'(ROUND_SEC);
         fcnt_n   = '0;
         winner_n = 2'b00;
         state_n  = FIGHT;
`ifdef COMBO_SCALE_EN
         last_atk_n = 2'd0;
         combo_n    = 2'd0;
         since_n    = '0;
`endif
      end else begin
         if (elig1 && elig2) begin
            grant1 = ~prio;
            grant2 = prio;
            prio_n = ~prio;
         end else begin
            grant1 = elig1;
            grant2 = elig2;
         end
         ack1_n = grant1;
         ack2_n = grant2;

         if (state == FIGHT) begin
            if (grant1) begin
               hp2_n = apply_hit(hp2, dmg1);
               if (hp2_n == '0) begin
                  ko       = 1'b1;
                  winner_n = 2'b01;
               end
            end
            if (grant2) begin
               hp1_n = apply_hit(hp1, dmg2);
               if (hp1_n == '0) begin
                  ko       = 1'b1;
                  winner_n = 2'b10;
               end
            end
`ifdef COMBO_SCALE_EN
            if (grant1 || grant2) begin
               last_atk_n = grant1 ? 2'd1 : 2'd2;
               combo_n    = grant1 ? combo1 : combo2;
               since_n    = '0;
            end else if (frame_tick && since != CF_W'(COMBO_WINDOW + 1)) begin
               since_n = since + 1'b1;
            end
`endif
            if (frame_tick) begin
               if (fcnt == FC_W'(FRAMES_PER_SEC - 1)) begin
                  fcnt_n = '0;
                  if (round_time != 7'd0) begin
                     time_n  = round_time - 7'd1;
                     time_up = (round_time == 7'd1);
                  end
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
            // KO has already chosen the winner when both happen together.
            if (ko) begin
               state_n = OVER;
            end else if (time_up) begin
               state_n  = OVER;
               winner_n = (hp1_n > hp2_n) ? 2'b01 :
                          (hp2_n > hp1_n) ? 2'b10 : 2'b11;
            end
         end
      end
   end

endmodule
